// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// vending_pkg : coin encodings and shared parameter defaults
// Revision 1.0
// ============================================================================
package vending_pkg;

  typedef enum logic {
    COIN_1 = 1'b0,
    COIN_2 = 1'b1
  } coin_t;

  localparam int c_debounce_cycles = 4;
  localparam int c_fifo_depth      = 4;
  localparam int c_count_w         = 4;

endpackage : vending_pkg
`default_nettype wire

// File: rtl/coin_acceptor_if.sv
`default_nettype none
// ============================================================================
// coin_acceptor_if : raw coin sensors, hold control and coin pulse outputs
// Revision 1.0
// ============================================================================
interface coin_acceptor_if;

  logic       coin_1_raw;
  logic       coin_2_raw;
  logic       hold;
  logic       coin_1;
  logic       coin_2;
  logic       reject;
  logic [3:0] queue_count;

  modport slave (
    input  coin_1_raw,
    input  coin_2_raw,
    input  hold,
    output coin_1,
    output coin_2,
    output reject,
    output queue_count
  );

  modport master (
    output coin_1_raw,
    output coin_2_raw,
    output hold,
    input  coin_1,
    input  coin_2,
    input  reject,
    input  queue_count
  );

endinterface : coin_acceptor_if
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// ============================================================================
// coin_debounce : per-channel synchronizer, debouncer, arm flag, rise event
// Revision 1.0
// ============================================================================
module coin_debounce
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_debounce_cycles
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_raw,
  output logic      o_event
);

  localparam logic [3:0] c_last = 4'(DEBOUNCE_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_prime;
  logic [3:0] r_cnt;
  logic [3:0] r_low_cnt;
  logic       r_deb;
  logic       r_deb_d;
  logic       r_armed;
  logic       r_event;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prime   <= 2'b00;
      r_cnt     <= 4'd0;
      r_low_cnt <= 4'd0;
      r_deb     <= 1'b0;
      r_deb_d   <= 1'b0;
      r_armed   <= 1'b0;
      r_event   <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_prime <= {r_prime[0], 1'b1};
      r_deb_d <= r_deb;

      if (r_sync2 != r_deb) begin
        if (r_cnt == c_last) begin
          r_deb <= r_sync2;
          r_cnt <= 4'd0;
          // A confirmed fall proves the sensor idles low, so the channel may arm.
          if (!r_sync2) r_armed <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        r_cnt <= 4'd0;
      end

      // Clean start: arm after a stable low run once the synchronizer holds real samples.
      if (r_prime[1] && !r_sync2 && !r_deb) begin
        if (r_low_cnt == c_last) r_armed <= 1'b1;
        else r_low_cnt <= r_low_cnt + 4'd1;
      end else begin
        r_low_cnt <= 4'd0;
      end

      r_event <= r_deb & ~r_deb_d & r_armed;
    end
  end

  assign o_event = r_event;

endmodule : coin_debounce
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// coin_acceptor : debounced coin detection, event queue and pulse issue
// Revision 1.0
// ============================================================================
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_debounce_cycles,
  parameter int FIFO_DEPTH      = c_fifo_depth
) (
  input  wire logic      clk,
  input  wire logic      reset,
  coin_acceptor_if.slave bus
);

  localparam int                   c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_count_w-1:0] c_depth = c_count_w'(FIFO_DEPTH);
  localparam logic [c_aw-1:0]      c_one   = c_aw'(1);

  logic                   w_ev1;
  logic                   w_ev2;
  logic [FIFO_DEPTH-1:0]  r_mem;
  logic [c_aw-1:0]        r_wr_ptr;
  logic [c_aw-1:0]        r_rd_ptr;
  logic [c_count_w-1:0]   r_count;
  logic                   r_coin_1;
  logic                   r_coin_2;
  logic                   r_reject;
  logic [c_count_w-1:0]   w_free;
  logic                   w_pop;
  logic                   w_push1;
  logic                   w_push2;
  logic                   w_drop;
  logic [c_count_w-1:0]   w_npush;
  logic [c_aw-1:0]        w_wr_ptr_p1;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_1 (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (bus.coin_1_raw),
    .o_event (w_ev1)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_2 (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (bus.coin_2_raw),
    .o_event (w_ev2)
  );

  // Admission uses the occupancy at the start of the cycle; a same-cycle pop does not free a slot.
  always_comb begin
    w_free      = c_depth - r_count;
    w_pop       = (r_count != '0) && !bus.hold && !(r_coin_1 || r_coin_2);
    w_push1     = w_ev1 && (w_free != '0);
    w_push2     = w_ev2 && (w_free > {{(c_count_w-1){1'b0}}, w_push1});
    w_drop      = (w_ev1 && !w_push1) || (w_ev2 && !w_push2);
    w_npush     = {{(c_count_w-1){1'b0}}, w_push1} + {{(c_count_w-1){1'b0}}, w_push2};
    w_wr_ptr_p1 = r_wr_ptr + c_one;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_coin_1 <= 1'b0;
      r_coin_2 <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      if (w_push1) r_mem[r_wr_ptr] <= COIN_1;
      if (w_push2) r_mem[w_push1 ? w_wr_ptr_p1 : r_wr_ptr] <= COIN_2;
      r_wr_ptr <= r_wr_ptr + w_npush[c_aw-1:0];
      r_rd_ptr <= r_rd_ptr + c_aw'(w_pop);
      r_count  <= r_count + w_npush - {{(c_count_w-1){1'b0}}, w_pop};
      r_coin_1 <= w_pop && (coin_t'(r_mem[r_rd_ptr]) == COIN_1);
      r_coin_2 <= w_pop && (coin_t'(r_mem[r_rd_ptr]) == COIN_2);
      r_reject <= w_drop;
    end
  end

  assign bus.coin_1      = r_coin_1;
  assign bus.coin_2      = r_coin_2;
  assign bus.reject      = r_reject;
  assign bus.queue_count = r_count;

endmodule : coin_acceptor
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// tb_coin_acceptor : scoreboard bench with directed coin scenarios
// Revision 1.0
// ============================================================================
module tb_coin_acceptor;
  import vending_pkg::*;

  localparam int c_deb = 4;
  localparam int c_lat = c_deb + 4;

  typedef struct {
    coin_t coin;
    int    cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   exp_rej;
  bit   stim_done;
  bit   prev_pulse;
  exp_t sb[$];

  coin_acceptor_if bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(c_deb), .FIFO_DEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected pulse for a raw edge driven at this negedge (first sampled at next posedge).
  task automatic expect_coin(input coin_t c, input int timed);
    sb.push_back('{coin: c, cyc: (timed != 0) ? cyc + 1 + c_lat : -1});
  endtask

  task automatic coin_pulse(input bit two, input int hi, input int lo);
    if (two) bus.coin_2_raw = 1'b1; else bus.coin_1_raw = 1'b1;
    step(hi);
    if (two) bus.coin_2_raw = 1'b0; else bus.coin_1_raw = 1'b0;
    step(lo);
  endtask

  initial begin
    int h;
    n_cmp = 0; n_err = 0; exp_rej = 0; stim_done = 1'b0; prev_pulse = 1'b0;
    reset = 1'b1;
    bus.coin_1_raw = 1'b0;
    bus.coin_2_raw = 1'b0;
    bus.hold = 1'b0;
    fork
      begin : stim
        step(3);
        chk("reset_count", int'(bus.queue_count), 0);
        chk("reset_outputs", int'({bus.coin_1, bus.coin_2, bus.reject}), 0);
        reset = 1'b0;
        step(10);

        // Single clean coin_1: exact latency and occupancy.
        expect_coin(COIN_1, 1);
        bus.coin_1_raw = 1'b1;
        step(8);
        chk("t1_count_one", int'(bus.queue_count), 1);
        step(1);
        chk("t1_count_zero", int'(bus.queue_count), 0);
        step(20);
        bus.coin_1_raw = 1'b0;
        step(15);

        // Bouncing coin_2 yields one pulse.
        expect_coin(COIN_2, 0);
        bus.coin_2_raw = 1'b1; step(1);
        bus.coin_2_raw = 1'b0; step(1);
        bus.coin_2_raw = 1'b1; step(1);
        bus.coin_2_raw = 1'b0; step(1);
        bus.coin_2_raw = 1'b1;
        step(25);
        chk("t2_count_zero", int'(bus.queue_count), 0);
        bus.coin_2_raw = 1'b0;
        step(15);

        // Simultaneous coins: coin_1 first, one idle cycle, then coin_2.
        sb.push_back('{coin: COIN_1, cyc: cyc + 1 + c_lat});
        sb.push_back('{coin: COIN_2, cyc: cyc + 3 + c_lat});
        bus.coin_1_raw = 1'b1;
        bus.coin_2_raw = 1'b1;
        step(8);
        chk("t3_count_two", int'(bus.queue_count), 2);
        step(1);
        chk("t3_count_after_c1", int'(bus.queue_count), 1);
        step(2);
        chk("t3_count_zero", int'(bus.queue_count), 0);
        bus.coin_1_raw = 1'b0;
        bus.coin_2_raw = 1'b0;
        step(20);

        // Hold with overflow: six coins, four kept, two rejected.
        bus.hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
          if (i >= 4) exp_rej++;
          coin_pulse(1'b0, 10, 10);
        end
        chk("t4_count_full", int'(bus.queue_count), 4);
        h = cyc;
        for (int i = 0; i < 4; i++) sb.push_back('{coin: COIN_1, cyc: h + 1 + 2 * i});
        bus.hold = 1'b0;
        step(20);
        chk("t4_count_drained", int'(bus.queue_count), 0);

        // Input held high through reset release stays silent until it cycles low.
        bus.coin_1_raw = 1'b1;
        reset = 1'b1;
        step(3);
        chk("t5_reset_count", int'(bus.queue_count), 0);
        reset = 1'b0;
        step(30);
        chk("t5_count_silent", int'(bus.queue_count), 0);
        bus.coin_1_raw = 1'b0;
        step(6);
        expect_coin(COIN_1, 1);
        bus.coin_1_raw = 1'b1;
        step(25);
        bus.coin_1_raw = 1'b0;
        step(15);

        // Reset with queued coins discards them.
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) coin_pulse(1'b0, 10, 10);
        chk("t6_count_three", int'(bus.queue_count), 3);
        reset = 1'b1;
        bus.hold = 1'b0;
        step(2);
        chk("t6_reset_count", int'(bus.queue_count), 0);
        reset = 1'b0;
        step(1);
        chk("t6_after_reset_count", int'(bus.queue_count), 0);
        step(15);
        expect_coin(COIN_1, 1);
        bus.coin_1_raw = 1'b1;
        step(12);
        bus.coin_1_raw = 1'b0;
        step(15);
        stim_done = 1'b1;
      end
      begin : monitor
        while (!stim_done) begin
          @(negedge clk);
          if (bus.coin_1 || bus.coin_2) begin
            chk("pulse_onehot", int'(bus.coin_1 & bus.coin_2), 0);
            chk("pulse_gap", int'(prev_pulse), 0);
            chk("pulse_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              exp_t e;
              e = sb.pop_front();
              chk("pulse_type", int'(bus.coin_2), int'(e.coin));
              if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
            end
          end
          if (bus.reject) begin
            chk("reject_expected", int'(exp_rej > 0), 1);
            if (exp_rej > 0) exp_rej--;
          end
          prev_pulse = bus.coin_1 || bus.coin_2;
        end
      end
    join
    chk("scoreboard_drained", sb.size(), 0);
    chk("rejects_drained", exp_rej, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_coin_acceptor
`default_nettype wire
